// File: rtl/mux4_ser_pkg.sv
// Shared types and index constants for the 4-bit mux-based serializer.
package mux4_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0] IDX_FIRST_LSB = 2'd0;
  localparam logic [1:0] IDX_LAST_LSB  = 2'd3;

  // Index of the first bit sent for the selected bit order.
  function automatic logic [1:0] first_idx(input bit msb_first);
    return msb_first ? IDX_LAST_LSB : IDX_FIRST_LSB;
  endfunction

  // Index of the bit that ends a word for the selected bit order.
  function automatic logic [1:0] last_idx(input bit msb_first);
    return msb_first ? IDX_FIRST_LSB : IDX_LAST_LSB;
  endfunction

endpackage

// File: rtl/mux4_serializer_mux4.sv
// 4:1 single-bit multiplexer used as the serializer's bit-select datapath.
module mux4 (
  input  logic [1:0] sel,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic       y
);

  // NOTE: a full case with a default keeps this purely combinational (no latch).
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/mux4_serializer.sv
// Valid/ready 4-bit parallel-to-serial converter; FSM and registers here, bit select in mux4.
// Optional zero-bubble back-to-back words: define MUX4_SER_BACK2BACK_EN.
module mux4_serializer
  import mux4_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy
);

  localparam logic [1:0] START_IDX = first_idx(MSB_FIRST);
  localparam logic [1:0] FINAL_IDX = last_idx(MSB_FIRST);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic       sel_bit;
  logic       capture;
  logic       xfer;
  logic       at_last;

  assign capture = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;
  assign at_last = (state_q == SHIFT) && (idx_q == FINAL_IDX);

  // State register. hold is a plain 4-bit register, so it is cleared on reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic. The index is reset to the start position when a word ends,
  // so a wrapped index never selects data.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          hold_d  = in_data;
          idx_d   = START_IDX;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (idx_q == FINAL_IDX) begin
`ifdef MUX4_SER_BACK2BACK_EN
            if (capture) begin
              hold_d  = in_data;
              idx_d   = START_IDX;
              state_d = SHIFT;
            end else begin
              idx_d   = START_IDX;
              state_d = IDLE;
            end
`else
            idx_d   = START_IDX;
            state_d = IDLE;
`endif
          end else begin
            idx_d = MSB_FIRST ? idx_q - 2'd1 : idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output logic. in_ready is held low while rst is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = at_last;
        busy      = 1'b1;
`ifdef MUX4_SER_BACK2BACK_EN
        // Accept only when the last bit is leaving too, so a word is never taken without room.
        in_ready  = at_last && out_ready;
`endif
      end
      default: ;
    endcase
  end

  mux4 u_mux4 (
    .sel (idx_q),
    .d0  (hold_q[0]),
    .d1  (hold_q[1]),
    .d2  (hold_q[2]),
    .d3  (hold_q[3]),
    .y   (sel_bit)
  );

  assign out_bit = sel_bit && out_valid;

endmodule

// File: tb/tb_mux4_serializer.sv
// Self-checking bench for mux4_serializer: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a queue-of-bits reference model.
module tb_mux4_serializer;

`ifdef MUX4_SER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       out_ready = 1'b0;

  logic l_in_ready, l_out_valid, l_out_bit, l_out_last, l_busy;
  logic m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit qa[$];
  bit qb[$];
  bit obs_a[$];
  bit obs_b[$];
  int obs_cyc[$];

  always #5 clk = ~clk;

  mux4_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_bit(l_out_bit),
    .out_last(l_out_last), .busy(l_busy)
  );

  mux4_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_bit(m_out_bit),
    .out_last(m_out_last), .busy(m_busy)
  );

  function automatic bit model_ready();
    if (rst) return 1'b0;
    return (qa.size() == 0) || (B2B && qa.size() == 1 && out_ready);
  endfunction

  // One clock: compare both instances with the model, advance the model, move to the next cycle.
  task automatic cycle();
    logic [4:0] exp_a, exp_b, got_a, got_b;
    bit ev, cap, xf;
    #1;
    ev    = !rst && (qa.size() > 0);
    exp_a = {model_ready(), ev, ev ? qa[0] : 1'b0, ev && qa.size() == 1, ev};
    exp_b = {model_ready(), ev, ev ? qb[0] : 1'b0, ev && qb.size() == 1, ev};
    got_a = {l_in_ready, l_out_valid, l_out_bit, l_out_last, l_busy};
    got_b = {m_in_ready, m_out_valid, m_out_bit, m_out_last, m_busy};
    checks++;
    if (got_a !== exp_a) begin
      errors++;
      $display("FAIL lsb_outputs cyc %0d: got rdy/vld/bit/last/busy=%b expected %b", cyc, got_a, exp_a);
    end
    checks++;
    if (got_b !== exp_b) begin
      errors++;
      $display("FAIL msb_outputs cyc %0d: got rdy/vld/bit/last/busy=%b expected %b", cyc, got_b, exp_b);
    end
    if (!rst && l_out_valid && out_ready) begin
      obs_a.push_back(l_out_bit);
      obs_b.push_back(m_out_bit);
      obs_cyc.push_back(cyc);
    end
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      cap = in_valid && model_ready();
      xf  = ev && out_ready;
      if (xf) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          qa.push_back(in_data[i]);
          qb.push_back(in_data[3-i]);
        end
      end
    end
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic clear_obs();
    obs_a.delete();
    obs_b.delete();
    obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    #1;
    checks++;
    if (l_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", l_in_ready);
    end
  endtask

  task automatic send_word(input logic [3:0] w, input int n);
    clear_obs();
    in_valid = 1'b1;
    in_data = w;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    in_data = ~w;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_single_word();
    logic [3:0] exp_l, exp_m, got_l, got_m;
    send_word(4'b1011, 6);
    exp_l = 4'b1011;  // bit order 1,1,0,1 read back as obs[0]..obs[3]
    exp_m = 4'b1101;  // 1,0,1,1
    got_l = 4'hx;
    got_m = 4'hx;
    if (obs_a.size() == 4)
      for (int i = 0; i < 4; i++) begin
        got_l[i] = obs_a[i];
        got_m[i] = obs_b[i];
      end
    checks++;
    if (got_l !== exp_l) begin
      errors++;
      $display("FAIL lsb_1011_sequence: got %b (n=%0d) expected %b", got_l, obs_a.size(), exp_l);
    end
    checks++;
    if (got_m !== exp_m) begin
      errors++;
      $display("FAIL msb_1011_sequence: got %b expected %b", got_m, exp_m);
    end
    checks++;
    if (obs_cyc.size() != 4 || obs_cyc[3] - obs_cyc[0] != 3) begin
      errors++;
      $display("FAIL lsb_1011_contiguous: got %0d bits expected 4 on consecutive cycles", obs_cyc.size());
    end
  endtask

  task automatic test_stall();
    logic [3:0] got;
    clear_obs();
    in_valid = 1'b1;
    in_data = 4'b0110;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && obs_a.size() < 2; i++) cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (l_out_valid !== 1'b1 || l_out_bit !== 1'b1 || l_out_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: got vld/bit/last=%b%b%b expected 110", i, l_out_valid, l_out_bit, l_out_last);
      end
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    got = 4'hx;
    if (obs_a.size() == 4) for (int i = 0; i < 4; i++) got[i] = obs_a[i];
    checks++;
    if (got !== 4'b0110) begin
      errors++;
      $display("FAIL stall_sequence: got %b (n=%0d) expected 0110", got, obs_a.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    int caps;
    int span;
    clear_obs();
    caps = 0;
    in_valid = 1'b1;
    in_data = 4'hA;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && obs_a.size() < 8; i++) begin
      bit will_cap;
      #1;
      will_cap = in_valid && model_ready();
      cycle();
      if (will_cap) begin
        caps++;
        in_data = 4'h5;
        if (caps == 2) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    got = 8'hxx;
    if (obs_a.size() == 8) for (int i = 0; i < 8; i++) got[i] = obs_a[i];
    checks++;
    if (got !== 8'b0101_1010) begin
      errors++;
      $display("FAIL b2b_sequence: got %b (n=%0d) expected 01011010 (bit0 first)", got, obs_a.size());
    end
    span = (obs_cyc.size() == 8) ? obs_cyc[7] - obs_cyc[0] + 1 : -1;
    checks++;
    if (span != (B2B ? 8 : 9)) begin
      errors++;
      $display("FAIL b2b_span: got %0d cycles expected %0d", span, B2B ? 8 : 9);
    end
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_midword_reset();
    clear_obs();
    in_valid = 1'b1;
    in_data = 4'hF;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && obs_a.size() < 2; i++) cycle();
    rst = 1'b1;
    #1;
    checks++;
    if ({l_in_ready, l_out_valid, l_out_bit, l_out_last, l_busy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b expected 00000",
               {l_in_ready, l_out_valid, l_out_bit, l_out_last, l_busy});
    end
    cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) cycle();
    checks++;
    if (obs_a.size() != 2) begin
      errors++;
      $display("FAIL reset_residual_bits: got %0d bits expected 2", obs_a.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom);
      out_ready = ($urandom_range(0, 4) != 0);
      if (i == 200) rst = 1'b1;
      if (i == 202) rst = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
  endtask

  initial begin
    #2;
    test_reset();
    test_single_word();
    test_stall();
    test_back_to_back();
    test_midword_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
